// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the serial binary-to-BCD converter and its
// seven-segment scan scheduler.
//   state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   WIDTH_DEF   : default binary input width
//   DIGITS_DEF  : default number of BCD digits
//   SEL_W       : width of the digit select bus
//   clog2()     : bits needed to hold the values 0..value-1 (minimum 1)
// -----------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int WIDTH_DEF  = 16;
   localparam int DIGITS_DEF = 5;
   localparam int SEL_W      = 3;

   // Never returns 0, so a counter sized from it is always at least 1 bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_scan_ctrl_if
// Bundles the conversion handshake and the display scan outputs.
//   ena         : scan enable (master -> slave)
//   load, bin   : conversion request and binary value (master -> slave)
//   busy, done  : conversion in progress / one-cycle result strobe
//   bcd         : registered BCD result, nibble 0 = ones digit
//   digit_sel   : digit currently driven on the shared decoder
//   digit_bcd   : nibble selected by digit_sel
//   digit_blank : 1 = leading zero, blank this digit
// -----------------------------------------------------------------------------
interface bcd_scan_ctrl_if
   import bcd_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DIGITS = DIGITS_DEF
);

   logic                  ena;
   logic                  load;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic [SEL_W-1:0]      digit_sel;
   logic [3:0]            digit_bcd;
   logic                  digit_blank;

   modport master (
      output ena, load, bin,
      input  busy, done, bcd, digit_sel, digit_bcd, digit_blank
   );

   modport slave (
      input  ena, load, bin,
      output busy, done, bcd, digit_sel, digit_bcd, digit_blank
   );

endinterface

// File: rtl/bcd_scan_ctrl_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Free-running digit scan: a prescaler counts 0..SCAN_DIV-1 and advances
// digit_sel at terminal count, wrapping at DIGITS-1. ena=0 freezes both.
//   clk, rst    : clock, async active-high reset
//   ena         : count enable
//   digit_sel   : current digit slot (0..DIGITS-1)
// -----------------------------------------------------------------------------
module scan_timer
   import bcd_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DIGITS   = DIGITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   output logic [SEL_W-1:0] digit_sel
);

   localparam int PRE_W = clog2(SCAN_DIV);

   logic [PRE_W-1:0] prescaler;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
         digit_sel <= '0;
      end else if (ena) begin
         if (prescaler == PRE_W'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            digit_sel <= (digit_sel == SEL_W'(DIGITS - 1)) ? '0
                                                            : digit_sel + SEL_W'(1);
         end else begin
            prescaler <= prescaler + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_scan_ctrl
// Serial double-dabble converter (one shift per clock) with a load/busy/done
// handshake, plus a time-multiplexed digit feed for one shared seg_7 decoder
// with leading-zero blanking.
//   clk, rst : clock, async active-high reset
//   bus      : bcd_scan_ctrl_if.slave (ena, load, bin -> busy, done, bcd,
//              digit_sel, digit_bcd, digit_blank)
// Latency: load sampled at edge 0, done/bcd valid after edge WIDTH+1.
// -----------------------------------------------------------------------------
module bcd_scan_ctrl
   import bcd_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DIGITS   = DIGITS_DEF,
   parameter int SCAN_DIV = 50000
) (
   input  logic           clk,
   input  logic           rst,
   bcd_scan_ctrl_if.slave bus
);

   localparam int CNT_W = clog2(WIDTH + 1);
   localparam int BCD_W = 4 * DIGITS;

   state_t             state, state_next;
   logic [WIDTH-1:0]   shift_q, shift_next;
   logic [BCD_W-1:0]   scratch_q, scratch_next, adjusted;
   logic [BCD_W-1:0]   bcd_q, bcd_next;
   logic [CNT_W-1:0]   cnt_q, cnt_next;
   logic               done_q, done_next;
   logic [SEL_W-1:0]   digit_sel;
   logic               upper_nonzero;

   // Double-dabble correction: any nibble >= 5 would overflow past 9 once
   // doubled, so bias it by 3 before the shift.
   always_comb begin
      adjusted = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next   = state;
      shift_next   = shift_q;
      scratch_next = scratch_q;
      cnt_next     = cnt_q;
      bcd_next     = bcd_q;
      done_next    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load) begin
               shift_next   = bus.bin;
               scratch_next = '0;
               cnt_next     = CNT_W'(WIDTH);
               state_next   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_next, shift_next} = {adjusted, shift_q} << 1;
            cnt_next = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // bcd only ever changes here, so a partial result is never visible.
            bcd_next   = scratch_q;
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_next;
         shift_q   <= shift_next;
         scratch_q <= scratch_next;
         cnt_q     <= cnt_next;
         bcd_q     <= bcd_next;
         done_q    <= done_next;
      end
   end

   scan_timer #(
      .SCAN_DIV (SCAN_DIV),
      .DIGITS   (DIGITS)
   ) u_scan_timer (
      .clk       (clk),
      .rst       (rst),
      .ena       (bus.ena),
      .digit_sel (digit_sel)
   );

   // Digit mux and leading-zero detect: blank when this digit and every more
   // significant one are zero; digit 0 always shows.
   always_comb begin
      bus.digit_bcd = '0;
      upper_nonzero = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_sel == SEL_W'(i)) begin
            bus.digit_bcd = bcd_q[4*i +: 4];
         end
         if ((SEL_W'(i) >= digit_sel) && (bcd_q[4*i +: 4] != 4'd0)) begin
            upper_nonzero = 1'b1;
         end
      end
      bus.digit_blank = (digit_sel != '0) && !upper_nonzero;
   end

   assign bus.busy      = (state == SHIFT);
   assign bus.done      = done_q;
   assign bus.bcd       = bcd_q;
   assign bus.digit_sel = digit_sel;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_ctrl
// Scoreboarded bench for bcd_scan_ctrl (WIDTH=16, DIGITS=5, SCAN_DIV=4).
// Accepted loads push the expected BCD value and done cycle; a negedge monitor
// pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_bcd_scan_ctrl;
   import bcd_pkg::*;

   localparam int WIDTH    = 16;
   localparam int DIGITS   = 5;
   localparam int SCAN_DIV = 4;
   localparam int LAT      = WIDTH + 2;   // negedge before load edge -> done negedge

   typedef struct {
      logic [31:0] bcd;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   done_prev = 1'b0;
   exp_t sb_q[$];

   bcd_scan_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   bcd_scan_ctrl #(
      .WIDTH    (WIDTH),
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp_v, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int value);
      logic [31:0] r;
      int v;
      r = '0;
      v = value;
      for (int i = 0; i < DIGITS; i++) begin
         r = r | (32'(v % 10) << (4 * i));
         v = v / 10;
      end
      return r;
   endfunction

   // Drive load for exactly one sampling edge; push expectation if it should be taken.
   task automatic do_load(input int value, input bit accept);
      exp_t e;
      @(negedge clk);
      bus.load = 1'b1;
      bus.bin  = 16'(value);
      if (accept) begin
         e.bcd = to_bcd(value);
         e.cyc = cyc + LAT;
         sb_q.push_back(e);
      end
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic wait_done(output int busy_cnt);
      bit got;
      got = 1'b0;
      busy_cnt = bus.busy ? 1 : 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (bus.done) got = 1'b1;
         else if (bus.busy) busy_cnt++;
      end
      if (!got) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic scan_check(input logic [31:0] exp_bcd);
      logic [4:0] seen;
      int sel;
      seen = '0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         sel = int'(bus.digit_sel);
         check("digit_sel_range", 32'(sel < DIGITS), 32'd1);
         if (sel < DIGITS) begin
            seen[sel] = 1'b1;
            check("digit_bcd", 32'(bus.digit_bcd), (exp_bcd >> (4 * sel)) & 32'hf);
            check("digit_blank", 32'(bus.digit_blank),
                  32'((sel != 0) && ((exp_bcd >> (4 * sel)) == 0)));
         end
      end
      check("digits_seen", 32'(seen), 32'h1f);
   endtask

   // Scoreboard monitor: every done must match the oldest accepted load.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.done) begin
         check("done_pulse", 32'(done_prev), 32'd0);
         if (sb_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("bcd", 32'(bus.bcd), e.bcd);
         end
      end
      done_prev <= bus.done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cnt;
      rst      = 1'b1;
      bus.ena  = 1'b0;
      bus.load = 1'b0;
      bus.bin  = '0;
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      bus.ena = 1'b1;

      // Reset state and scan stepping with SCAN_DIV=4.
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_bcd", 32'(bus.bcd), 32'd0);
      for (int k = 0; k <= 13; k++) begin
         if (k > 0) @(negedge clk);
         check("scan_sel", 32'(bus.digit_sel), 32'((k / 4) % DIGITS));
      end
      bus.ena = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("scan_frozen", 32'(bus.digit_sel), 32'd3);
      end
      bus.ena = 1'b1;
      for (int k = 14; k <= 25; k++) begin
         @(negedge clk);
         check("scan_resume", 32'(bus.digit_sel), 32'((k / 4) % DIGITS));
      end

      // Single conversion: busy for WIDTH cycles, one-cycle done.
      do_load(12345, 1'b1);
      wait_done(busy_cnt);
      check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
      @(negedge clk);
      check("done_low_after", 32'(bus.done), 32'd0);

      // Extremes.
      do_load(65535, 1'b1);
      wait_done(busy_cnt);
      do_load(0, 1'b1);
      wait_done(busy_cnt);
      scan_check(32'h0);

      // Loads during SHIFT (edges 5 and 16 after the accepted one) are ignored.
      do_load(42, 1'b1);
      repeat (3) @(negedge clk);
      do_load(999, 1'b0);
      repeat (9) @(negedge clk);
      do_load(999, 1'b0);
      wait_done(busy_cnt);
      repeat (25) @(negedge clk);
      check("bcd_hold_42", 32'(bus.bcd), 32'h42);
      scan_check(32'h42);

      // Async reset mid-conversion aborts it; outputs clear with no clock edge.
      do_load(12345, 1'b1);
      repeat (8) @(negedge clk);
      #2;
      rst = 1'b1;
      sb_q.delete();
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_bcd", 32'(bus.bcd), 32'd0);
      check("arst_sel", 32'(bus.digit_sel), 32'd0);
      check("arst_digit", 32'(bus.digit_bcd), 32'd0);
      check("arst_blank", 32'(bus.digit_blank), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("bcd_after_abort", 32'(bus.bcd), 32'd0);
      do_load(321, 1'b1);
      wait_done(busy_cnt);
      repeat (5) @(negedge clk);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
Sequential binary-to-BCD controller and display scheduler for the counter/seven-segment path. It accepts a binary count on a load request and converts it serially with iterative double-dabble, one shift per clock, behind a load/busy/done handshake. It publishes the registered BCD result and time-multiplexes it onto one shared seg_7 decoder, with a digit select and leading-zero blanking. It sits between the counter and a single seg_7 instance, in place of a combinational converter feeding one decoder per digit.

Parameters:
WIDTH, 16, binary input width.
DIGITS, 5, BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1.
SCAN_DIV, 50000, clk cycles per digit slot during scanning. Must be >= 1.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
ena  input  1  scan enable; 0 freezes prescaler and digit_sel.
load  input  1  conversion request; sampled only in IDLE.
bin  input  WIDTH  binary value; captured on an accepted load.
busy  output  1  1 while a conversion is in progress (SHIFT state).
done  output  1  one-cycle pulse when bcd updates.
bcd  output  4*DIGITS  registered result; nibble 0 is the ones digit.
digit_sel  output  3  index of the digit currently driven (0..DIGITS-1).
digit_bcd  output  4  nibble of bcd selected by digit_sel; drives shared seg_7.
digit_blank  output  1  1 = blank this digit (leading zero).

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, bcd=0, digit_sel=0, prescaler=0, shift and scratch registers=0. A conversion in progress is aborted; it does not resume after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when load=1, capture bin into the shift register, clear the 4*DIGITS scratch, set bit counter to WIDTH, go to SHIFT. busy goes to 1 in the next cycle.
- SHIFT, each cycle:
  - Add 3 to every scratch nibble >= 5.
  - Then shift {scratch, shift} left by 1.
  - Decrement the bit counter.
  - After the WIDTH-th shift, go to DONE.
- DONE (1 cycle): bcd <= scratch, done=1, busy=0, then IDLE.
- Latency: load sampled at edge 0, done high and bcd valid after edge WIDTH+1 (17 cycles for defaults). Back-to-back throughput is one conversion per WIDTH+2 cycles.
- load while in SHIFT or DONE is ignored; no queuing. bin changes during a conversion have no effect.
- bcd holds its previous value for the whole conversion and never shows a partial result.
- Scan timer runs independently of the FSM, while ena=1:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count, prescaler returns to 0 and digit_sel increments.
  - digit_sel wraps from DIGITS-1 to 0.
  - ena=0 holds both counters.
- digit_bcd = bcd[4*digit_sel +: 4], combinational from registered state.
- digit_blank = 1 iff digit_sel != 0 and nibbles digit_sel..DIGITS-1 are all zero. Digit 0 is never blanked, so value 0 displays "0".
- A bcd update mid-slot takes effect on digit_bcd and digit_blank in the cycle after done.

Decomposition:
- Shared package bcd_pkg holds:
  - state typedef {IDLE, SHIFT, DONE};
  - default constants WIDTH=16, DIGITS=5;
  - function clog2 for sizing the bit counter and prescaler.
- One sub-module, scan_timer (prescaler plus digit_sel counter with wrap, params SCAN_DIV and DIGITS), instantiated once.
- Double-dabble FSM and blanking logic stay in bcd_scan_ctrl.

Test Plan:
- Assert rst mid-cycle with no clk edge -> all outputs 0 immediately, digit_blank=0.
- load=1 one cycle with bin=12345 -> busy=1 for 16 cycles, done pulse 17 cycles after load, bcd=0x12345, done low the next cycle.
- bin=65535 then bin=0, each converted -> bcd=0x65535, then bcd=0x00000. With value 0, digit_blank=1 for digit_sel 1..4 and 0 for digit_sel 0, digit_bcd=0.
- load 00042, then pulse load with bin=999 at cycles 5 and 16 -> second request ignored, bcd=0x00042. digit_blank is 1 for digits 2..4 and 0 for digits 0..1.
- SCAN_DIV=4, ena=1 -> digit_sel steps 0,1,2,3,4,0, each held 4 cycles. Dropping ena for 10 cycles freezes digit_sel and prescaler, and scanning resumes from the same count.
- load 12345, assert rst at SHIFT cycle 8, release, load 321 -> no done from the first request, bcd=0 after reset, then bcd=0x00321 exactly 17 cycles after the second load.
